// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//
// Program loader for pipelined_datapath. It takes a stream of instruction words
// over a valid/ready handshake and writes them into instruction memory at
// consecutive word addresses starting from 0. The CPU is held in reset for the
// whole load and is released only after the final write has committed.
//
// Optional feature macro: IMEM_LOADER_FILL_EN
//   Defined     : after the last program word, every remaining address up to
//                 the top of memory is written with 0 (NOP) before release.
//   Not defined : the CPU is released right after the last program write, and
//                 stale contents above the program are left untouched.
//
// Parameters
//   ADDR_W      instruction-memory word-address width (depth = 2**ADDR_W)
//   DATA_W      instruction width (the word is not interpreted)
//
// Ports
//   clk          in   system clock, rising edge
//   reset        in   asynchronous active-low reset
//   load_start   in   single-cycle request to begin a (re)load
//   in_valid     in   upstream word valid
//   in_ready     out  loader accepts a word this cycle (registered)
//   in_data      in   instruction word
//   in_last      in   final word of the program, qualified by in_valid
//   imem_we      out  instruction-memory write enable (registered)
//   imem_addr    out  write word address (registered)
//   imem_wdata   out  write data (registered)
//   cpu_reset    out  active-high reset for pipelined_datapath
//   load_done    out  program loaded and CPU released
//   err_overflow out  memory filled without seeing in_last
//   word_count   out  words accepted in the current load
//   dbg_state    out  current FSM state encoding, for observation only
// -----------------------------------------------------------------------------
module imem_loader #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0] imem_wdata,
    output logic              cpu_reset,
    output logic              load_done,
    output logic              err_overflow,
    output logic [ADDR_W:0]   word_count,
    output logic [2:0]        dbg_state
);

    // Handshake: a word transfers on every rising edge where in_valid and
    // in_ready are both 1. in_ready is a register driven purely from the next
    // state, so it never depends combinationally on in_valid; the producer may
    // hold in_valid high and get one word per cycle with no bubbles. in_data
    // and in_last are only looked at on a transfer edge.

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_RUN  = 3'd2,
        S_ERR  = 3'd3
`ifdef IMEM_LOADER_FILL_EN
        ,
        S_FILL = 3'd4
`endif
    } state_e;

    localparam logic [ADDR_W-1:0] PTR_TOP = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [ADDR_W:0]     cnt_q, cnt_d;
    logic                in_ready_q, in_ready_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                cpu_reset_q, cpu_reset_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                accept;

    assign accept = in_valid && in_ready_q;

    // -------------------------------------------------------------------------
    // State and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cpu_reset_q <= 1'b1;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cpu_reset_q <= cpu_reset_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and registered-output logic
    //
    // The write port is one cycle behind acceptance. When the last write is
    // accepted the FSM already moves to RUN (or ERR), but the status flags are
    // derived one edge later, on the edge that commits that write. That edge
    // is the first one where done_q/err_q can be set, which is also why a
    // load_start during the first RUN/ERR cycle is ignored: the restart is only
    // honoured once the flag is up, so no write is ever outstanding while the
    // CPU is out of reset.
    // -------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        we_d        = 1'b0;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cpu_reset_d = 1'b1;
        done_d      = 1'b0;
        err_d       = 1'b0;

        case (state_q)
            S_IDLE: begin
                ptr_d = '0;
                cnt_d = '0;
                if (load_start) begin
                    state_d = S_LOAD;
                end
            end

            S_LOAD: begin
                if (accept) begin
                    we_d    = 1'b1;
                    addr_d  = ptr_q;
                    wdata_d = in_data;
                    ptr_d   = ptr_q + PTR_ONE;
                    cnt_d   = cnt_q + CNT_ONE;
                    if (in_last) begin
`ifdef IMEM_LOADER_FILL_EN
                        // Nothing left to zero when the program ends at the
                        // top address, so skip FILL entirely.
                        state_d = (ptr_q == PTR_TOP) ? S_RUN : S_FILL;
`else
                        state_d = S_RUN;
`endif
                    end else if (ptr_q == PTR_TOP) begin
                        // Memory is full and the program has not ended; the
                        // word at the top address is still written.
                        state_d = S_ERR;
                    end
                end
            end

`ifdef IMEM_LOADER_FILL_EN
            S_FILL: begin
                we_d    = 1'b1;
                addr_d  = ptr_q;
                wdata_d = '0;
                ptr_d   = ptr_q + PTR_ONE;
                if (ptr_q == PTR_TOP) begin
                    state_d = S_RUN;
                end
            end
`endif

            S_RUN: begin
                if (done_q && load_start) begin
                    state_d = S_LOAD;
                    ptr_d   = '0;
                    cnt_d   = '0;
                end else begin
                    cpu_reset_d = 1'b0;
                    done_d      = 1'b1;
                end
            end

            S_ERR: begin
                if (err_q && load_start) begin
                    state_d = S_LOAD;
                    ptr_d   = '0;
                    cnt_d   = '0;
                end else begin
                    err_d = 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        in_ready_d = (state_d == S_LOAD);
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign in_ready     = in_ready_q;
    assign imem_we      = we_q;
    assign imem_addr    = addr_q;
    assign imem_wdata   = wdata_q;
    assign cpu_reset    = cpu_reset_q;
    assign load_done    = done_q;
    assign err_overflow = err_q;
    assign word_count   = cnt_q;
    assign dbg_state    = state_q;

    // -------------------------------------------------------------------------
    // Structural invariants
    // -------------------------------------------------------------------------
`ifndef SYNTHESIS
    // The CPU never runs while a write to its instruction memory is pending.
    a_no_write_when_released: assert property (
        @(posedge clk) disable iff (!reset) !(we_q && !cpu_reset_q));

    // in_ready is asserted exactly while loading.
    a_ready_only_in_load: assert property (
        @(posedge clk) disable iff (!reset) in_ready_q == (state_q == S_LOAD));

    // Status flags only ever appear in their own states.
    a_done_in_run: assert property (
        @(posedge clk) disable iff (!reset) !done_q || (state_q == S_RUN));
    a_err_in_err: assert property (
        @(posedge clk) disable iff (!reset) !err_q || (state_q == S_ERR));
    a_release_matches_done: assert property (
        @(posedge clk) disable iff (!reset) cpu_reset_q == !done_q);
`endif

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
//
// Bench for imem_loader. Stimulus is randomised valid toggling and data; a
// spec-level model (phase, pointer, count and a queue of expected writes) runs
// alongside the DUT and is compared every cycle. A shadow array stands in for
// the instruction memory and is checked with hand-computed literals.
// Build with +define+IMEM_LOADER_FILL_EN to exercise the NOP-fill variant.
// -----------------------------------------------------------------------------
module tb_imem_loader;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 1 << ADDR_W;
`ifdef IMEM_LOADER_FILL_EN
    localparam bit FILL = 1'b1;
`else
    localparam bit FILL = 1'b0;
`endif

    // Model phases
    localparam int P_IDLE = 0;
    localparam int P_LOAD = 1;
    localparam int P_FILL = 2;
    localparam int P_RUN  = 3;
    localparam int P_ERR  = 4;

    // ------------------------------------------------------------ clock/reset
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic              load_start;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_last;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_wdata;
    logic              cpu_reset;
    logic              load_done;
    logic              err_overflow;
    logic [ADDR_W:0]   word_count;
    logic [2:0]        dbg_state;

    imem_loader #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .load_start  (load_start),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_last     (in_last),
        .imem_we     (imem_we),
        .imem_addr   (imem_addr),
        .imem_wdata  (imem_wdata),
        .cpu_reset   (cpu_reset),
        .load_done   (load_done),
        .err_overflow(err_overflow),
        .word_count  (word_count),
        .dbg_state   (dbg_state)
    );

    // ------------------------------------------------------------ bookkeeping
    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    logic [DATA_W-1:0] shadow [DEPTH];
    logic [DATA_W-1:0] prog   [DEPTH];

    // ------------------------------------------------------------ model
    logic [ADDR_W+DATA_W-1:0] exp_q[$];
    int   m_ph, m_ptr, m_cnt;
    bit   m_rel, m_err;
    bit   pend_we;
    logic [ADDR_W-1:0] pend_addr;
    logic [DATA_W-1:0] pend_data;
    int   cyc = 0;
    int   wr_cnt, last_wr_cyc, fall_cyc;
    bit   rel_seen;

    task automatic model_reset();
        m_ph    = P_IDLE;
        m_ptr   = 0;
        m_cnt   = 0;
        m_rel   = 1'b0;
        m_err   = 1'b0;
        pend_we = 1'b0;
        exp_q.delete();
    endtask

    // Advances the model over one rising edge using the inputs held before it.
    task automatic model_step();
        case (m_ph)
            P_IDLE: begin
                m_ptr = 0;
                m_cnt = 0;
                if (load_start) m_ph = P_LOAD;
            end
            P_LOAD: begin
                if (in_valid) begin
                    exp_q.push_back({ADDR_W'(m_ptr), in_data});
                    m_cnt++;
                    if (in_last) m_ph = (FILL && m_ptr != DEPTH - 1) ? P_FILL : P_RUN;
                    else if (m_ptr == DEPTH - 1) m_ph = P_ERR;
                    m_ptr = (m_ptr + 1) % DEPTH;
                end
            end
            P_FILL: begin
                exp_q.push_back({ADDR_W'(m_ptr), {DATA_W{1'b0}}});
                if (m_ptr == DEPTH - 1) m_ph = P_RUN;
                m_ptr = (m_ptr + 1) % DEPTH;
            end
            P_RUN: begin
                if (m_rel && load_start) begin
                    m_ph = P_LOAD; m_rel = 1'b0; m_ptr = 0; m_cnt = 0;
                end else m_rel = 1'b1;
            end
            default: begin
                if (m_err && load_start) begin
                    m_ph = P_LOAD; m_err = 1'b0; m_ptr = 0; m_cnt = 0;
                end else m_err = 1'b1;
            end
        endcase
    endtask

    task automatic compare();
        logic [ADDR_W+DATA_W-1:0] e;
        int n;
        n = exp_q.size();
        check("in_ready", in_ready, m_ph == P_LOAD);
        check("cpu_reset", cpu_reset, !(m_ph == P_RUN && m_rel));
        check("load_done", load_done, m_ph == P_RUN && m_rel);
        check("err_overflow", err_overflow, m_ph == P_ERR && m_err);
        check("word_count", word_count, m_cnt);
        check("imem_we", imem_we, n > 0);
        if (n > 0) begin
            e = exp_q.pop_front();
            if (imem_we) begin
                check("imem_addr", imem_addr, e[ADDR_W+DATA_W-1:DATA_W]);
                check("imem_wdata", imem_wdata, e[DATA_W-1:0]);
            end
        end
        pend_we   = imem_we;
        pend_addr = imem_addr;
        pend_data = imem_wdata;
        if (imem_we) begin
            wr_cnt++;
            last_wr_cyc = cyc;
        end
        if (!cpu_reset && !rel_seen) begin
            rel_seen = 1'b1;
            fall_cyc = cyc;
        end
    endtask

    // Compare process: model advances on each rising edge, DUT is sampled 2ns later.
    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            cyc++;
            if (!reset) begin
                model_reset();
            end else begin
                if (pend_we) shadow[pend_addr] = pend_data;
                pend_we = 1'b0;
                model_step();
                #2;
                if (reset) compare();
            end
        end
    end

    // ------------------------------------------------------------ drivers
    task automatic start_load();
        @(negedge clk);
        wr_cnt   = 0;
        rel_seen = 1'b0;
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
    endtask

    task automatic send_prog(input int n, input bit last_en, input int pct);
        int i = 0;
        int guard = 0;
        while (i < n && guard < 20 * n + 100) begin
            @(negedge clk);
            guard++;
            in_valid = ($urandom_range(0, 99) < pct);
            in_data  = in_valid ? prog[i] : $urandom;
            in_last  = in_valid ? (last_en && i == n - 1) : 1'($urandom_range(0, 1));
            if (in_valid && in_ready) i++;
        end
        check("send_bound", i, n);
    endtask

    task automatic end_stream(input bit poke_start);
        @(negedge clk);
        in_valid   = 1'b0;
        in_last    = 1'b0;
        load_start = poke_start;
        @(negedge clk);
        load_start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            if (load_done || err_overflow) break;
        end
        check("wait_done_bound", load_done || err_overflow, 1);
    endtask

    // ------------------------------------------------------------ watchdog
    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog: run did not complete, errors=%0d", errors);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------ main sequence
    logic [DATA_W-1:0] old_top;

    initial begin
        reset      = 1'b0;
        load_start = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        in_last    = 1'b0;
        for (int i = 0; i < DEPTH; i++) shadow[i] = 32'hDEAD_BEEF;
        for (int i = 0; i < DEPTH; i++) prog[i] = 32'hA500_0000 | 32'(i);

        // Reset values
        repeat (3) @(negedge clk);
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_imem_we", imem_we, 0);
        check("rst_imem_addr", imem_addr, 0);
        check("rst_imem_wdata", imem_wdata, 0);
        check("rst_cpu_reset", cpu_reset, 1);
        check("rst_load_done", load_done, 0);
        check("rst_err", err_overflow, 0);
        check("rst_word_count", word_count, 0);
        check("rst_state", dbg_state, 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_no_ready", in_ready, 0);

        // 29-word program, in_valid held high
        start_load();
        send_prog(29, 1'b1, 100);
        end_stream(1'b0);
        wait_done(600);
        check("t1_word_count", word_count, 29);
        check("t1_mem0", shadow[0], 32'hA500_0000);
        check("t1_mem28", shadow[28], 32'hA500_001C);
        check("t1_mem29", shadow[29], FILL ? 32'h0 : 32'hDEAD_BEEF);
        check("t1_write_count", wr_cnt, FILL ? 256 : 29);
        check("t1_release_latency", fall_cyc - last_wr_cyc, 1);
        check("t1_cpu_reset", cpu_reset, 0);

        // Same stream with random stalls; restart from RUN and poke load_start
        // on the first RUN cycle, which must be ignored.
        repeat (4) @(negedge clk);
        for (int i = 0; i < 29; i++) shadow[i] = 32'h0;
        start_load();
        send_prog(29, 1'b1, 50);
        end_stream(1'b1);
        wait_done(800);
        repeat (5) @(negedge clk);
        check("t2_still_done", load_done, 1);
        check("t2_word_count", word_count, 29);
        for (int i = 0; i < 29; i++) check("t2_image", shadow[i], 32'hA500_0000 | 32'(i));
        check("t2_release_latency", fall_cyc - last_wr_cyc, 1);

        // 1-word load from RUN
        prog[0] = 32'h1234_5678;
        start_load();
        send_prog(1, 1'b1, 100);
        end_stream(1'b0);
        wait_done(600);
        check("t3_mem0", shadow[0], 32'h1234_5678);
        check("t3_word_count", word_count, 1);

        // Overflow: 256 words without in_last
        for (int i = 0; i < DEPTH; i++) prog[i] = $urandom;
        start_load();
        send_prog(256, 1'b0, 80);
        end_stream(1'b0);
        wait_done(100);
        repeat (3) @(negedge clk);
        check("t4_err", err_overflow, 1);
        check("t4_cpu_reset", cpu_reset, 1);
        check("t4_in_ready", in_ready, 0);
        check("t4_load_done", load_done, 0);
        check("t4_word_count", word_count, 256);
        check("t4_mem_top", shadow[255], prog[255]);
        old_top = prog[255];

        // Restart from ERR with a 3-word program; preload 0xC8
        for (int i = 0; i < 3; i++) prog[i] = $urandom;
        shadow[200] = 32'hFFFF_FFFF;
        start_load();
        send_prog(3, 1'b1, 60);
        end_stream(1'b0);
        wait_done(600);
        check("t5_err_clear", err_overflow, 0);
        check("t5_word_count", word_count, 3);
        check("t5_mem0", shadow[0], prog[0]);
        check("t5_mem2", shadow[2], prog[2]);
        check("t5_mem_c8", shadow[200], FILL ? 32'h0 : 32'hFFFF_FFFF);
        check("t5_mem_top", shadow[255], FILL ? 32'h0 : old_top);
        check("t5_write_count", wr_cnt, FILL ? 256 : 3);
        check("t5_release_latency", fall_cyc - last_wr_cyc, 1);

        // Asynchronous reset after 10 accepted words
        for (int i = 0; i < 16; i++) begin
            prog[i]   = 32'hC0DE_0000 | 32'(i + 1);
            shadow[i] = 32'h0;
        end
        start_load();
        send_prog(10, 1'b0, 70);
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check("ar_in_ready", in_ready, 0);
        check("ar_imem_we", imem_we, 0);
        check("ar_imem_addr", imem_addr, 0);
        check("ar_cpu_reset", cpu_reset, 1);
        check("ar_load_done", load_done, 0);
        check("ar_word_count", word_count, 0);
        repeat (2) @(negedge clk);
        check("ar_mem8", shadow[8], 32'hC0DE_0009);
        check("ar_mem9_not_written", shadow[9], 32'h0);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        check("ar_idle_state", dbg_state, 0);
        check("ar_idle_ready", in_ready, 0);
        start_load();
        send_prog(2, 1'b1, 100);
        end_stream(1'b0);
        wait_done(600);
        check("ar_word_count_after", word_count, 2);
        check("ar_mem1_after", shadow[1], 32'hC0DE_0002);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
